// File: rtl/xgri_mc_pkg.sv
// xgri_mc_pkg: register field encodings and status/control bit positions for xgri_mc
package xgri_mc_pkg;
  localparam logic [1:0] FLD_STATUS = 2'd0;
  localparam logic [1:0] FLD_ADDR = 2'd1;
  localparam logic [1:0] FLD_DATA = 2'd2;
  localparam logic [1:0] FLD_STRIDE = 2'd3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_RUNS = 4;
  localparam int ST_LEVEL = 8;
  localparam int CTL_FLUSH = 15;
endpackage

// File: rtl/xgri_mc_fifo.sv
// xgri_mc_fifo: first-word fall-through FIFO with flush; level port exists only with XGRI_MC_LEVEL_EN
module xgri_mc_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
`ifdef XGRI_MC_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);
  localparam int AB = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AB:0] wp_q, wp_d, rp_q, rp_d;
  logic pop_ok, push_ok;
  // pointers carry one wrap bit so full and empty need no separate counter
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q ^ rp_q) == {1'b1, {AB{1'b0}}};
    pop_ok = pop & ~empty;
    push_ok = push & ~flush & (~full | pop_ok);
    wp_d = flush ? '0 : wp_q + {{AB{1'b0}}, push_ok};
    rp_d = flush ? '0 : rp_q + {{AB{1'b0}}, pop_ok};
    dout = empty ? '0 : mem[rp_q[AB-1:0]];
  end
`ifdef XGRI_MC_LEVEL_EN
  assign level = wp_q - rp_q;
`endif
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk_sys)
    if (push_ok) mem[wp_q[AB-1:0]] <= din;
endmodule

// File: rtl/xgri_mc.sv
// xgri_mc: CH-channel CPU-to-XGMM write interface with FIFOs, auto-stepping addresses and flush.
// Build option XGRI_MC_LEVEL_EN reports FIFO occupancy in status[15:8].
module xgri_mc
  import xgri_mc_pkg::*;
#(
  parameter int CH = 2,
  parameter int AW = 13,
  parameter int DEPTH = 16,
  parameter int RUNS_DEF = 4,
  parameter int STRIDE_DEF = 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             ri_en,
  input  logic             ri_wren,
  input  logic             ri_ren,
  input  logic [3:0]       ri_addr,
  input  logic [15:0]      from_cpu,
  output logic [15:0]      to_cpu,
  output logic [CH-1:0]    ch_full,
  output logic [CH-1:0]    ch_empty,
  input  logic [CH-1:0]    ch_pop,
  output logic [16*CH-1:0] ch_data,
  output logic [AW*CH-1:0] ch_addr
);
  logic wr, rd;
  logic [1:0] sel, fld;
  logic [3:0][15:0] rd_word;
  logic [15:0] to_cpu_q, to_cpu_d;
  assign wr = ri_en & ri_wren;
  assign rd = ri_en & ri_ren;
  assign sel = ri_addr[3:2];
  assign fld = ri_addr[1:0];
  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < CH) begin : g_on
      logic hit, flush, push, run_end, step, clr, full, empty;
      logic [AW-1:0] addr_q, addr_d, stride_q, stride_d;
      logic [3:0] runs_q, runs_d, cnt_q, cnt_d;
      logic ovf_q, ovf_d, prev_q, prev_d;
      logic [15:0] head, status;
      logic [7:0] lvl8;
`ifdef XGRI_MC_LEVEL_EN
      logic [$clog2(DEPTH):0] level;
      logic [8:0] lvl9;
      assign lvl9 = 9'(level);
      assign lvl8 = lvl9[8] ? 8'hff : lvl9[7:0];
`else
      assign lvl8 = '0;
`endif
      xgri_mc_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
        .clk_sys(clk_sys),
        .rst(rst),
        .push(push),
        .pop(ch_pop[c]),
        .flush(flush),
        .din(from_cpu),
        .dout(head),
        .full(full),
        .empty(empty)
`ifdef XGRI_MC_LEVEL_EN
        ,
        .level(level)
`endif
      );
      // step decision uses the counter before any empty-clear in the same cycle
      always_comb begin
        hit = sel == 2'(c);
        flush = wr & hit & (fld == FLD_STATUS) & from_cpu[CTL_FLUSH];
        push = wr & hit & (fld == FLD_DATA);
        clr = rd & hit & (fld == FLD_STATUS);
        run_end = prev_q & ~ch_pop[c];
        step = run_end & (cnt_q == runs_q);
        prev_d = ch_pop[c];
        cnt_d = (flush | empty) ? '0 : run_end ? (step ? '0 : cnt_q + 4'd1) : cnt_q;
        addr_d = (wr & hit & (fld == FLD_ADDR)) ? from_cpu[AW-1:0] : step ? addr_q + stride_q : addr_q;
        stride_d = (wr & hit & (fld == FLD_STRIDE)) ? from_cpu[AW-1:0] : stride_q;
        runs_d = (wr & hit & (fld == FLD_STATUS)) ? from_cpu[3:0] : runs_q;
        ovf_d = flush ? 1'b0 : (push & full & ~ch_pop[c]) ? 1'b1 : clr ? 1'b0 : ovf_q;
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_OVF] = ovf_q;
        status[ST_RUNS +: 4] = runs_q;
        status[ST_LEVEL +: 8] = lvl8;
      end
      assign rd_word[c] = fld == FLD_STATUS ? status :
                          fld == FLD_ADDR   ? 16'(addr_q) :
                          fld == FLD_STRIDE ? 16'(stride_q) : 16'h0;
      assign ch_full[c] = full;
      assign ch_empty[c] = empty;
      assign ch_data[16*c +: 16] = head;
      assign ch_addr[AW*c +: AW] = addr_q;
      always_ff @(posedge clk_sys or posedge rst)
        if (rst) begin
          addr_q <= '0;
          stride_q <= AW'(STRIDE_DEF);
          runs_q <= 4'(RUNS_DEF - 1);
          cnt_q <= '0;
          ovf_q <= 1'b0;
          prev_q <= 1'b0;
        end else begin
          addr_q <= addr_d;
          stride_q <= stride_d;
          runs_q <= runs_d;
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
          prev_q <= prev_d;
        end
    end else begin : g_off
      assign rd_word[c] = 16'h0;
    end
  end
  assign to_cpu_d = ri_en ? (ri_ren ? rd_word[sel] : 16'h0) : to_cpu_q;
  assign to_cpu = to_cpu_q;
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) to_cpu_q <= '0;
    else to_cpu_q <= to_cpu_d;
endmodule

// File: doc/xgri_mc.md
# xgri_mc

Multi-channel, parametrised register interface between the CPU register bus and the graphics memory manager (XGMM). Provides CH independent write channels. Each channel has a CPU-filled data FIFO, a memory address register that auto-advances by a programmable stride after a programmable number of pop runs, a flush control and sticky overflow status. Successor to the fixed two-channel pattern/attribute interface, with per-channel stride, run count, flush and fill-level readback.

## Interface
- CH, 2, number of channels (1..4)
- AW, 13, address register width (1..16)
- DEPTH, 16, FIFO depth per channel (power of 2, 4..256)
- RUNS_DEF, 4, reset value of pop runs per address step (1..16)
- STRIDE_DEF, 1, reset value of address stride

- clk_sys  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ri_en  in  1  register access strobe
- ri_wren  in  1  write qualifier
- ri_ren  in  1  read qualifier
- ri_addr  in  4  [3:2] channel, [1:0] field
- from_cpu  in  16  write data
- to_cpu  out  16  registered read data
- ch_full  out  CH  per-channel FIFO full
- ch_empty  out  CH  per-channel FIFO empty
- ch_pop  in  CH  per-channel pop from XGMM
- ch_data  out  16*CH  FIFO head, channel c at [16c+15:16c]
- ch_addr  out  AW*CH  address register, channel c at [AW*c+AW-1:AW*c]

## Operation
- Fields: 0 status/control, 1 address, 2 data push, 3 stride. Channel index >= CH: writes ignored, reads return 0.
- Status read: [0] empty, [1] full, [2] overflow (sticky), [7:4] runs_m1, [15:8] level (see Configuration), others 0.
- Control write (field 0): [3:0] -> runs_m1. [15] = 1 flushes the channel: FIFO emptied, run counter and overflow cleared.
- Field 1 write loads address from from_cpu[AW-1:0]. Read returns it, zero-extended.
- Field 3 write loads stride from from_cpu[AW-1:0]. Read returns it.
- Field 2 write pushes from_cpu. Push while full is dropped and sets overflow. Field 2 read returns 0.
- Overflow clears on a status read (ri_en & ri_ren, field 0) or a flush. A new overflow in the same cycle as the clearing read stays set.
- Pop run = one or more consecutive cycles of ch_pop high; the run ends on the first low cycle.
- On each run end, if run counter == runs_m1: address += stride (mod 2^AW), counter <= 0. Otherwise counter += 1.
- Run counter is cleared synchronously whenever the FIFO is empty. The address step uses the counter value before the clear. For the counter, clear has priority over increment.
- ch_pop while empty: ignored by the FIFO; run detection still operates.
- Simultaneous CPU address write and auto-step: CPU value wins.
- Simultaneous push and pop when full: both take effect; no overflow.
- Push in a flush cycle is dropped.

## Timing
- Reset values: to_cpu 0, ch_addr 0, stride STRIDE_DEF, runs_m1 RUNS_DEF-1, ch_empty all 1, ch_full all 0, ch_data 0, overflow 0.
- to_cpu updates at the edge that samples ri_en and holds otherwise. Read latency is 1 cycle.
- FIFO is first-word fall-through:
  - push into an empty FIFO at edge N: ch_data valid and ch_empty low after edge N;
  - pop sampled at edge N: next head after edge N.
- ch_full and level update at the same edge as the push or pop.
- Address step: ch_pop high in cycles k..m and low in cycle m+1; the new ch_addr is visible from cycle m+2. The previous-pop register resets to 0.
- Flush takes effect at the sampling edge.
- Reset mid-burst aborts the burst and restores all reset values immediately.

## Configuration
- XGRI_MC_LEVEL_EN defined: status [15:8] = FIFO occupancy, 0..DEPTH, saturating at 255.
- XGRI_MC_LEVEL_EN undefined: status [15:8] = 0, and no level output logic is built beyond what full/empty need.

## Structure
- Package xgri_mc_pkg holds:
  - field encoding constants (FLD_STATUS, FLD_ADDR, FLD_DATA, FLD_STRIDE);
  - status bit positions;
  - the control flush bit index.
- Sub-module xgri_mc_fifo: synchronous FIFO with push, pop, flush, full, empty and level. Instantiated once per channel with a generate loop.

## Test plan
- Reset, then read status ch0 -> to_cpu 0x0031 one cycle after the read strobe (empty, runs_m1 = 3).
- Push 16 words to ch1 (DEPTH 16), then one more -> ch_full[1] = 1. Status shows overflow = 1 and level 0x10 (LEVEL_EN). A second status read shows overflow 0.
- ch0: address 0x0100, stride 4, runs_m1 0, 4 words, pop two runs of 2 cycles -> ch_addr0 is 0x0104 then 0x0108, each visible 2 cycles after pop falls.
- Default runs (4): four single-cycle pop runs -> address steps once, by STRIDE_DEF. After a drain-and-empty the run counter restarts at 0.
- CPU writes address 0x0200 in the same cycle as an auto-step -> ch_addr = 0x0200.
- Flush ch0 while holding 8 words, with a push in the same cycle -> ch_empty[0] = 1 the next cycle, level 0, overflow 0.
